seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Keeps the existing 4-bit alu_control encoding for all logic, arithmetic and shift ops.
- Adds iterative multi-cycle multiply (full 2*WIDTH product) and divide (quotient and remainder), signed compare, overflow and divide-by-zero flags.
- Sits between the ID/EX register and the EX/MEM stage. The pipeline stalls while in_ready is low.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4, power of two).
- SHW, $clog2(WIDTH), width of the shift-amount port (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- shamt  input  SHW  shift amount for SLL/SRL/SRA
- alu_control  input  4  opcode
- out_valid  output  1  result registers hold a completed operation
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  primary result: product low half for MUL, quotient for DIV
- result_hi  output  WIDTH  product high half for MUL, remainder for DIV, 0 for all other ops
- zero  output  1  result == 0
- overflow  output  1  signed overflow on ADD/SUB, 0 for all other ops
- div_by_zero  output  1  DIV issued with b == 0

Behaviour:
- Reset (async, high): state=IDLE, in_ready=1, out_valid=0. result, result_hi, zero, overflow and div_by_zero all go to 0. Any in-flight MUL/DIV is discarded. Iteration counter and operand shadows are cleared.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - a, b, shamt and alu_control are captured at input transfer and need not be held afterwards.
- FSM states:
  - IDLE: in_ready=1. On input transfer of a MUL, or of a DIV with b!=0, go to BUSY. On any other input transfer, go to DONE. The result is registered at the same edge, so latency is 1.
  - BUSY: in_ready=0. One iteration per cycle for exactly WIDTH cycles, then go to DONE. MUL/DIV latency is WIDTH+1 cycles from input transfer to out_valid.
  - DONE: out_valid=1. Outputs are held stable until out_ready. On output transfer go to IDLE. A new request cannot be accepted in the same cycle, so single-cycle throughput is 1 op per 2 cycles.
- Opcodes (all unsigned unless stated):
  - 0000 AND; 0001 OR; 0100 XOR; 1100 NOR
  - 0010 ADD; 0110 SUB (both modulo 2^WIDTH)
  - 0111 SLTU: result = (a<b unsigned), zero-extended
  - 1101 SLT: signed compare, zero-extended
  - 1000 SLL a<<shamt; 1001 SRL a>>shamt; 1010 SRA, arithmetic, sign bit replicated
  - 0101 MUL: unsigned shift-add; {result_hi,result} = a*b
  - 1011 DIV: unsigned restoring division; result = a/b, result_hi = a%b
  - Any other code: ADD
- Overflow:
  - ADD: overflow when a and b have the same sign and the sum sign differs.
  - SUB: overflow when a and b have different signs and the difference sign differs from a.
- Divide by zero:
  - b==0 does not enter BUSY; it completes with latency 1.
  - result = all ones, result_hi = a, div_by_zero = 1.
- Flags:
  - zero is computed from the registered result only, never from result_hi.
  - zero, overflow and div_by_zero are valid only while out_valid=1.
- Shifts:
  - shamt=0 returns a unchanged.
  - shamt=WIDTH-1 is the maximum shift.
  - Upper bits of b are ignored for shifts.
- Boundary conditions:
  - in_valid while BUSY or DONE is ignored, because in_ready=0.
  - out_ready while not out_valid has no effect.
  - Reset asserted mid-BUSY aborts immediately. out_valid never rises for the aborted op.

Decomposition:
- Shared package (alu_pkg) holds:
  - 4-bit opcode localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLTU, OP_SLT, OP_SLL, OP_SRL, OP_SRA, OP_XOR, OP_MUL, OP_DIV.
  - FSM state encoding: IDLE, BUSY, DONE.
- One natural sub-module, seq_muldiv:
  - Iterative engine: start, is_div, a, b in; busy, done, lo, hi out; parametrised by WIDTH.
  - Holds the accumulator/remainder, shift registers and an SHW+1 bit counter.
- seq_alu owns the handshake FSM, the combinational single-cycle ops and the result/flag registers.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF b=1, out_ready=1 -> out_valid 1 cycle after transfer; result=0x80000000, overflow=1, zero=0.
- SUB a=5 b=5 -> result=0, zero=1, overflow=0. SLT a=0xFFFFFFFF b=1 -> result=1. SLTU with the same operands -> result=0.
- SRA a=0x80000000 shamt=31 -> result=0xFFFFFFFF. SRL with the same inputs -> result=1.
- MUL a=0xFFFFFFFF b=0xFFFFFFFF -> in_ready low for 32 cycles; out_valid at cycle 33; result=0x00000001, result_hi=0xFFFFFFFE.
- DIV a=100 b=7 -> after 33 cycles result=14, result_hi=2. DIV a=9 b=0 -> 1 cycle; result=0xFFFFFFFF, result_hi=9, div_by_zero=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after completion -> outputs stable, in_ready=0; consumed on the first out_ready.
  - Assert reset at cycle 10 of a MUL -> all outputs 0, in_ready=1, no out_valid.
  - Repeat the test at WIDTH=8: MUL 0xFF*0xFF -> hi=0xFE, lo=0x01.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding, handshake FSM states and decode helpers for seq_alu.
package alu_pkg;

   // 4-bit alu_control encoding, unchanged from the single-cycle datapath ALU
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_MUL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_DIV  = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_SLT  = 4'b1101;

   // Handshake FSM encoding
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Status flags produced alongside every result
   typedef struct packed {
      logic zero;
      logic overflow;
      logic div_by_zero;
   } alu_flags_t;

   // MUL always iterates; DIV iterates unless the divisor is zero
   function automatic logic needs_engine(input logic [3:0] op, input logic b_is_zero);
      return (op == OP_MUL) || ((op == OP_DIV) && !b_is_zero);
   endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// The first iteration is folded into the start cycle so the engine finishes
// WIDTH edges after start, with done pulsing in the cycle after the last step.
module seq_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned CW  = SHW + 1;

   logic [WIDTH-1:0] m;
   logic             div_q;
   logic [CW-1:0]    cnt;

   // One iteration: hi is the partial product / remainder, lo the multiplier / quotient
   function automatic logic [2*WIDTH-1:0] step(input logic d,
                                               input logic [WIDTH-1:0] h,
                                               input logic [WIDTH-1:0] l,
                                               input logic [WIDTH-1:0] mm);
      logic [WIDTH:0] sum;
      logic [WIDTH:0] r;
      logic [WIDTH:0] trial;
      r     = {h, l[WIDTH-1]};
      trial = r - {1'b0, mm};
      sum   = {1'b0, h} + (l[0] ? {1'b0, mm} : {(WIDTH+1){1'b0}});
      if (d) begin
         if (trial[WIDTH]) step = {r[WIDTH-1:0], l[WIDTH-2:0], 1'b0};
         else              step = {trial[WIDTH-1:0], l[WIDTH-2:0], 1'b1};
      end else begin
         step = {sum, l[WIDTH-1:1]};
      end
   endfunction

   // Operand shadows, iteration counter and the shared hi/lo shift registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         cnt   <= '0;
         m     <= '0;
         div_q <= 1'b0;
         lo    <= '0;
         hi    <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            {hi, lo} <= step(is_div, '0, is_div ? a : b, is_div ? b : a);
            m        <= is_div ? b : a;
            div_q    <= is_div;
            cnt      <= CW'(WIDTH - 1);
            busy     <= 1'b1;
         end else if (busy) begin
            {hi, lo} <= step(div_q, hi, lo, m);
            cnt      <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIV.
module seq_alu
   import alu_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             overflow,
   output logic             div_by_zero
);

   logic [1:0]       state, state_nxt;
   logic             xfer_in, xfer_out, start, b_zero;
   logic [WIDTH-1:0] sum, diff;
   logic [WIDTH-1:0] res_c, res_hi_c;
   alu_flags_t       flags_c;
   logic             md_busy, md_done;
   logic [WIDTH-1:0] md_lo, md_hi;

   assign b_zero   = (b == '0);
   assign xfer_in  = in_valid && (state == IDLE) && !md_busy;
   assign xfer_out = out_valid && out_ready;
   assign start    = xfer_in && needs_engine(alu_control, b_zero);
   assign sum      = a + b;
   assign diff     = a - b;

   seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .is_div (alu_control == OP_DIV),
      .a      (a),
      .b      (b),
      .busy   (md_busy),
      .done   (md_done),
      .lo     (md_lo),
      .hi     (md_hi)
   );

   // Single-cycle result, high word and flags for the current request
   always_comb begin
      res_c    = '0;
      res_hi_c = '0;
      flags_c  = '0;
      case (alu_control)
         OP_AND:  res_c = a & b;
         OP_OR:   res_c = a | b;
         OP_XOR:  res_c = a ^ b;
         OP_NOR:  res_c = ~(a | b);
         OP_SUB: begin
            res_c            = diff;
            flags_c.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLTU: res_c = WIDTH'(a < b);
         OP_SLT:  res_c = WIDTH'($signed(a) < $signed(b));
         OP_SLL:  res_c = a << shamt;
         OP_SRL:  res_c = a >> shamt;
         OP_SRA:  res_c = WIDTH'($signed(a) >>> shamt);
         OP_MUL:  res_c = '0;
         OP_DIV: begin
            // only reached with b == 0; nonzero divisors go through the engine
            res_c               = '1;
            res_hi_c            = a;
            flags_c.div_by_zero = 1'b1;
         end
         default: begin
            res_c            = sum;
            flags_c.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
      endcase
      flags_c.zero = (res_c == '0);
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (xfer_in)  state_nxt = start ? BUSY : DONE;
         BUSY:    if (md_done)  state_nxt = DONE;
         DONE:    if (xfer_out) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered handshake outputs, result and flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         result      <= '0;
         result_hi   <= '0;
         zero        <= 1'b0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         if (xfer_in && !start) begin
            result      <= res_c;
            result_hi   <= res_hi_c;
            zero        <= flags_c.zero;
            overflow    <= flags_c.overflow;
            div_by_zero <= flags_c.div_by_zero;
         end else if ((state == BUSY) && md_done) begin
            result      <= md_lo;
            result_hi   <= md_hi;
            zero        <= (md_lo == '0);
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8.
module tb_seq_alu;
   import alu_pkg::*;

   typedef struct {
      int          id;
      logic [31:0] res;
      logic [31:0] hi;
      logic        z;
      logic        ov;
      logic        dz;
      int          lat;
      int          xfer;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, result, result_hi;
   logic [4:0]  shamt;
   logic [3:0]  alu_control;
   logic        zero, overflow, div_by_zero;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  a8, b8, result8, result_hi8;
   logic [2:0]  shamt8;
   logic [3:0]  alu_control8;
   logic        zero8, overflow8, div_by_zero8;

   exp_t q32[$];
   exp_t q8[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   rise32 = 0, rise8 = 0;
   logic prev32 = 1'b0, prev8 = 1'b0;

   seq_alu #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .shamt(shamt), .alu_control(alu_control),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .result_hi(result_hi), .zero(zero), .overflow(overflow),
      .div_by_zero(div_by_zero)
   );

   seq_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .shamt(shamt8), .alu_control(alu_control8),
      .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
      .result_hi(result_hi8), .zero(zero8), .overflow(overflow8),
      .div_by_zero(div_by_zero8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1ms;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic check(input exp_t e, input logic [31:0] r, input logic [31:0] h,
                        input logic z, input logic ov, input logic dz,
                        input int rise, input string tag);
      int lat;
      lat = rise - e.xfer + 1;
      n_vec++;
      if (r !== e.res || h !== e.hi || z !== e.z || ov !== e.ov || dz !== e.dz || lat != e.lat) begin
         n_bad++;
         $display("FAIL %s vec%0d: got res=%h hi=%h z=%b ov=%b dz=%b lat=%0d, want res=%h hi=%h z=%b ov=%b dz=%b lat=%0d",
                  tag, e.id, r, h, z, ov, dz, lat, e.res, e.hi, e.z, e.ov, e.dz, e.lat);
      end
   endtask

   // Monitor for the 32-bit instance
   always @(negedge clk) begin
      exp_t e;
      if (out_valid && !prev32) rise32 = cyc;
      prev32 = out_valid;
      if (out_valid && out_ready) begin
         if (q32.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL w32 unexpected output res=%h hi=%h", result, result_hi);
         end else begin
            e = q32.pop_front();
            check(e, result, result_hi, zero, overflow, div_by_zero, rise32, "w32");
         end
      end
   end

   // Monitor for the 8-bit instance
   always @(negedge clk) begin
      exp_t e;
      if (out_valid8 && !prev8) rise8 = cyc;
      prev8 = out_valid8;
      if (out_valid8 && out_ready8) begin
         if (q8.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL w8 unexpected output res=%h hi=%h", result8, result_hi8);
         end else begin
            e = q8.pop_front();
            check(e, {24'h0, result8}, {24'h0, result_hi8}, zero8, overflow8, div_by_zero8, rise8, "w8");
         end
      end
   end

   task automatic issue32(input int id, input logic [3:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [4:0] sh,
                          input logic [31:0] er, input logic [31:0] eh,
                          input logic ez, input logic eov, input logic edz,
                          input int elat, input bit push);
      int   n;
      exp_t e;
      n = 0;
      alu_control = op; a = av; b = bv; shamt = sh; in_valid = 1'b1;
      while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
      if (!in_ready) begin
         n_vec++; n_bad++;
         $display("FAIL w32 in_ready timeout vec%0d", id);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      e.id = id; e.res = er; e.hi = eh; e.z = ez; e.ov = eov; e.dz = edz;
      e.lat = elat; e.xfer = cyc;
      if (push) q32.push_back(e);
      // operands need not be held after the transfer
      a = ~av; b = ~bv; shamt = ~sh; alu_control = 4'b1111;
   endtask

   task automatic issue8(input int id, input logic [3:0] op, input logic [7:0] av,
                         input logic [7:0] bv, input logic [2:0] sh,
                         input logic [7:0] er, input logic [7:0] eh,
                         input logic ez, input logic eov, input logic edz,
                         input int elat);
      int   n;
      exp_t e;
      n = 0;
      alu_control8 = op; a8 = av; b8 = bv; shamt8 = sh; in_valid8 = 1'b1;
      while (!in_ready8 && n < 300) begin @(posedge clk); #1; n++; end
      if (!in_ready8) begin
         n_vec++; n_bad++;
         $display("FAIL w8 in_ready timeout vec%0d", id);
         in_valid8 = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      e.id = id; e.res = {24'h0, er}; e.hi = {24'h0, eh}; e.z = ez; e.ov = eov; e.dz = edz;
      e.lat = elat; e.xfer = cyc;
      q8.push_back(e);
      a8 = ~av; b8 = ~bv; shamt8 = ~sh; alu_control8 = 4'b1111;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q32.size() != 0 || q8.size() != 0) && n < 500) begin @(posedge clk); n++; end
      #1;
      n_vec++;
      if (q32.size() != 0 || q8.size() != 0) begin
         n_bad++;
         $display("FAIL drain timeout: pending w32=%0d w8=%0d want 0", q32.size(), q8.size());
      end
   endtask

   initial begin
      bit ok;
      reset = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; shamt = '0; alu_control = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; shamt8 = '0; alu_control8 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || result_hi !== 32'h0 ||
          zero !== 1'b0 || overflow !== 1'b0 || div_by_zero !== 1'b0 ||
          in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || result8 !== 8'h0) begin
         n_bad++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b res=%h hi=%h flags=%b%b%b, want 1 0 0 0 000",
                  in_ready, out_valid, result, result_hi, zero, overflow, div_by_zero);
      end
      @(posedge clk); #1;
      reset = 1'b0;

      // single-cycle ops: id, op, a, b, shamt, res, hi, z, ov, dz, latency
      issue32( 1, OP_ADD,  32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 32'h0, 0, 1, 0, 1, 1);
      issue32( 2, OP_SUB,  32'd5,        32'd5,        5'd0,  32'h0,        32'h0, 1, 0, 0, 1, 1);
      issue32( 3, OP_SLT,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        32'h0, 0, 0, 0, 1, 1);
      issue32( 4, OP_SLTU, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        32'h0, 1, 0, 0, 1, 1);
      issue32( 5, OP_SRA,  32'h80000000, 32'h0,        5'd31, 32'hFFFFFFFF, 32'h0, 0, 0, 0, 1, 1);
      issue32( 6, OP_SRL,  32'h80000000, 32'h0,        5'd31, 32'h1,        32'h0, 0, 0, 0, 1, 1);
      issue32( 7, OP_SLL,  32'h3,        32'hFFFFFFFF, 5'd31, 32'h80000000, 32'h0, 0, 0, 0, 1, 1);
      issue32( 8, OP_SLL,  32'h1234,     32'hFFFFFFFF, 5'd0,  32'h1234,     32'h0, 0, 0, 0, 1, 1);
      issue32( 9, OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 32'h0, 0, 0, 0, 1, 1);
      issue32(10, OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 32'h0, 0, 0, 0, 1, 1);
      issue32(11, OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 32'h0, 0, 0, 0, 1, 1);
      issue32(12, OP_NOR,  32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 32'h0, 0, 0, 0, 1, 1);
      issue32(13, OP_SUB,  32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 32'h0, 0, 1, 0, 1, 1);
      issue32(14, OP_ADD,  32'h80000000, 32'h80000000, 5'd0,  32'h0,        32'h0, 1, 1, 0, 1, 1);
      issue32(15, 4'b0011, 32'd2,        32'd3,        5'd0,  32'd5,        32'h0, 0, 0, 0, 1, 1);

      // multi-cycle ops
      issue32(16, OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h1,        32'hFFFFFFFE, 0, 0, 0, 33, 1);
      // requests while BUSY must be ignored
      ok = 1'b1;
      in_valid = 1'b1; alu_control = OP_ADD; a = 32'h1; b = 32'h1;
      for (int i = 0; i < 20; i++) begin
         if (in_ready !== 1'b0) ok = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_vec++;
      if (!ok) begin n_bad++; $display("FAIL busy_in_ready: got 1 while BUSY, want 0"); end

      issue32(17, OP_MUL,  32'h12345,    32'h0,        5'd0,  32'h0,        32'h0, 1, 0, 0, 33, 1);
      issue32(18, OP_MUL,  32'h10000,    32'h10000,    5'd0,  32'h0,        32'h1, 1, 0, 0, 33, 1);
      issue32(19, OP_DIV,  32'd100,      32'd7,        5'd0,  32'd14,       32'd2, 0, 0, 0, 33, 1);
      issue32(20, OP_DIV,  32'hFFFFFFFF, 32'd1,        5'd0,  32'hFFFFFFFF, 32'h0, 0, 0, 0, 33, 1);
      issue32(21, OP_DIV,  32'd7,        32'd100,      5'd0,  32'h0,        32'd7, 1, 0, 0, 33, 1);
      issue32(22, OP_DIV,  32'd9,        32'd0,        5'd0,  32'hFFFFFFFF, 32'd9, 0, 0, 1, 1, 1);
      drain();

      // backpressure: result held and new requests ignored while DONE
      out_ready = 1'b0;
      issue32(23, OP_XOR,  32'hA5,       32'h5A,       5'd0,  32'hFF,       32'h0, 0, 0, 0, 1, 1);
      ok = 1'b1;
      in_valid = 1'b1; alu_control = OP_ADD; a = 32'h10; b = 32'h20;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || result !== 32'hFF || in_ready !== 1'b0) ok = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL backpressure_hold: out_valid=%b res=%h in_ready=%b, want 1 000000ff 0",
                  out_valid, result, in_ready);
      end
      out_ready = 1'b1;
      drain();

      // reset mid-MUL aborts the operation
      issue32(24, OP_MUL,  32'h1234,     32'h5678,     5'd0,  32'h0,        32'h0, 0, 0, 0, 33, 0);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || result_hi !== 32'h0 ||
          zero !== 1'b0 || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_abort: in_ready=%b out_valid=%b res=%h hi=%h, want 1 0 0 0",
                  in_ready, out_valid, result, result_hi);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      ok = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (out_valid !== 1'b0) ok = 1'b0;
      end
      n_vec++;
      if (!ok) begin n_bad++; $display("FAIL reset_abort_valid: out_valid rose, want 0"); end
      @(posedge clk); #1;
      issue32(25, OP_ADD,  32'd2,        32'd3,        5'd0,  32'd5,        32'h0, 0, 0, 0, 1, 1);

      // WIDTH=8 instance
      issue8(31, OP_MUL, 8'hFF, 8'hFF, 3'd0, 8'h01, 8'hFE, 0, 0, 0, 9);
      issue8(32, OP_DIV, 8'd200, 8'd7, 3'd0, 8'd28, 8'd4,  0, 0, 0, 9);
      issue8(33, OP_SRA, 8'h80, 8'h00, 3'd7, 8'hFF, 8'h00, 0, 0, 0, 1);
      issue8(34, OP_ADD, 8'h7F, 8'h01, 3'd0, 8'h80, 8'h00, 0, 1, 0, 1);
      issue8(35, OP_DIV, 8'd5,  8'd0,  3'd0, 8'hFF, 8'd5,  0, 0, 1, 1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
